// File: rtl/dot_product_pkg.sv
// dot_product_pkg: shared FSM states and sizing helpers for the dot-product MAC stage
package dot_product_pkg;
  typedef enum logic [1:0] {ACC, DRAIN, DONE} state_e;
  localparam int N_TERMS_DEF = 4;
  function automatic int acc_w(input int n_terms);
    return 8 + $clog2(n_terms);
  endfunction
endpackage

// File: rtl/Multiplier.sv
// Multiplier: 4x4 unsigned array multiplier, purely combinational
module Multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 4; i++) p = p + ({4'b0, a & {4{b[i]}}} << i);
  end
endmodule

// File: rtl/dot_product_acc.sv
// dot_product_acc: streams 4-bit operand pairs through Multiplier and sums
// N_TERMS products into one dot product behind valid/ready handshakes
module dot_product_acc
  import dot_product_pkg::*;
#(
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = acc_w(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);
  localparam int CW = $clog2(N_TERMS) + 1;
  state_e           state_q;
  logic [3:0]       a_q, b_q;
  logic             v1_q, out_valid_q;
  logic [ACC_W-1:0] acc_q, out_sum_q, acc_d;
  logic [CW-1:0]    term_cnt_q;
  logic [7:0]       prod;
  logic             accept;
  Multiplier u_mul (.a(a_q), .b(b_q), .p(prod));
  assign in_ready  = (state_q == ACC);
  assign accept    = in_valid && in_ready;
  assign acc_d     = v1_q ? acc_q + ACC_W'(prod) : acc_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      state_q     <= ACC;
      a_q         <= '0;
      b_q         <= '0;
      v1_q        <= 1'b0;
      acc_q       <= '0;
      term_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      case (state_q)
        ACC: begin
          acc_q <= acc_d;
          if (accept) begin
            if (term_cnt_q == CW'(N_TERMS - 1)) state_q <= DRAIN;
            else term_cnt_q <= term_cnt_q + 1'b1;
          end
        end
        // last term still sits in stage 1, so fold it straight into the result
        DRAIN: begin
          out_sum_q   <= acc_d;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          term_cnt_q  <= '0;
          state_q     <= DONE;
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_acc.sv
// tb_dot_product_acc: directed vectors with hand-computed dot products
module tb_dot_product_acc;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] out_sum;
  int errors = 0;
  int checks = 0;
  dot_product_acc dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input int a, input int b);
    in_valid = 1'b1;
    in_a = 4'(a);
    in_b = 4'(b);
    tick();
    in_valid = 1'b0;
  endtask
  task automatic push_n(input int a, input int b, input int n);
    for (int i = 0; i < n; i++) push(a, b);
  endtask
  task automatic wait_out(input string tag, input int exp);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk(tag, int'(out_sum), exp);
  endtask
  initial begin
    #3;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push(1, 2); push(3, 4); push(5, 6); push(7, 8);
    chk("basic_drain_ready", int'(in_ready), 0);
    chk("basic_drain_valid", int'(out_valid), 0);
    tick();
    chk("basic_valid", int'(out_valid), 1);
    chk("basic_sum", int'(out_sum), 100);
    chk("basic_done_ready", int'(in_ready), 0);
    tick();
    chk("basic_valid_drop", int'(out_valid), 0);
    chk("basic_ready_back", int'(in_ready), 1);
    push_n(15, 15, 4);
    wait_out("max", 900);
    tick();
    push(0, 9); push(2, 3); push(0, 15); push(4, 0);
    wait_out("zero", 6);
    tick();
    out_ready = 1'b0;
    push_n(5, 5, 4);
    wait_out("bp", 100);
    in_valid = 1'b1;
    in_a = 4'd2;
    in_b = 4'd2;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_sum", int'(out_sum), 100);
      chk("bp_hold_ready", int'(in_ready), 0);
      chk("bp_hold_valid", int'(out_valid), 1);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_one_hs", int'(out_valid), 0);
    chk("bp_ready_after", int'(in_ready), 1);
    push_n(2, 2, 4);
    wait_out("bp_second", 16);
    tick();
    push(9, 9);
    repeat (3) tick();
    chk("gap_hold_ready", int'(in_ready), 1);
    push(1, 1);
    tick();
    push(2, 3); push(4, 4);
    wait_out("gaps", 104);
    tick();
    push_n(3, 3, 2);
    clr = 1'b1;
    in_valid = 1'b1;
    in_a = 4'd3;
    in_b = 4'd3;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    chk("clr_ready", int'(in_ready), 1);
    chk("clr_valid", int'(out_valid), 0);
    push_n(1, 1, 4);
    wait_out("clr_fresh", 4);
    tick();
    out_ready = 1'b0;
    push_n(1, 1, 4);
    wait_out("clr_done_pre", 4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_done_valid", int'(out_valid), 0);
    chk("clr_done_sum", int'(out_sum), 0);
    chk("clr_done_ready", int'(in_ready), 1);
    out_ready = 1'b1;
    push_n(1, 2, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mid_ready", int'(in_ready), 1);
    chk("arst_mid_valid", int'(out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    out_ready = 1'b0;
    push_n(1, 2, 4);
    wait_out("arst_pre", 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_valid", int'(out_valid), 0);
    chk("arst_done_sum", int'(out_sum), 0);
    chk("arst_done_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    push_n(1, 2, 4);
    wait_out("arst_after", 8);
    tick();
    chk("final_valid", int'(out_valid), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
